// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B LED chain driver: pixel format,
// GRB field offsets, default latch gap and the frame-source state encoding.
package ws2812b_pkg;

    localparam int PIXEL_W              = 24;
    localparam int G_LSB                = 16;
    localparam int R_LSB                = 8;
    localparam int B_LSB                = 0;
    localparam int DEFAULT_LATCH_CYCLES = 1200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LATCH  = 2'd2
    } ws_state_e;

    // Assemble a GRB word from its three colour channels.
    function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g,
                                                    input logic [7:0] r,
                                                    input logic [7:0] b);
        logic [PIXEL_W-1:0] w;
        w = '0;
        w[G_LSB +: 8] = g;
        w[R_LSB +: 8] = r;
        w[B_LSB +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/ws2812b_pixel_bank.sv
// Double-buffered pixel store: writes always land in the back bank, the
// front bank is read combinationally by index, and a toggle swaps roles.
module ws2812b_pixel_bank
    import ws2812b_pkg::*;
#(
    parameter int LED_COUNT = 8,
    parameter int AW        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [PIXEL_W-1:0] wr_data_i,
    input  logic               toggle_i,
    input  logic [AW-1:0]      rd_idx_i,
    output logic [PIXEL_W-1:0] rd_data_o
);

    logic [PIXEL_W-1:0] bank_q [2][LED_COUNT];
    logic               bank_sel_q;

    // Back-bank write (addresses past the chain are dropped) and bank swap;
    // the write uses the pre-swap back bank so it shows in the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < LED_COUNT; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            bank_sel_q <= 1'b0;
        end else begin
            if (wr_en_i && (32'(wr_addr_i) < LED_COUNT)) begin
                bank_q[~bank_sel_q][wr_addr_i] <= wr_data_i;
            end
            if (toggle_i) begin
                bank_sel_q <= ~bank_sel_q;
            end
        end
    end

    assign rd_data_o = bank_q[bank_sel_q][rd_idx_i];

endmodule

// File: rtl/ws2812b_frame_source.sv
// Frame source for the WS2812B chain: triggers a frame on the free-running
// frame timer or on kick, streams the committed pixels over valid/ready,
// then holds off for the LED latch gap before accepting the next trigger.
module ws2812b_frame_source
    import ws2812b_pkg::*;
#(
    parameter int  LED_COUNT    = 8,
    parameter int  FRAME_PERIOD = 12000000,
    parameter int  LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    localparam int AW           = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [PIXEL_W-1:0] wr_data_i,
    input  logic               commit_i,
    input  logic               kick_i,
    output logic               frame_start_o,
    output logic               pix_valid_o,
    output logic [PIXEL_W-1:0] pix_data_o,
    output logic               pix_last_o,
    input  logic               pix_ready_i,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    ws_state_e          state_q;
    logic [AW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic [TW-1:0]      timer_q, timer_d;
    logic               swap_pend_q, swap_pend_d;
    logic               frame_start_q, pix_valid_q, busy_q, overrun_q;
    logic               timer_wrap, trigger, swap_now, at_last;
    logic [PIXEL_W-1:0] front_data;

    ws2812b_pixel_bank #(
        .LED_COUNT (LED_COUNT),
        .AW        (AW)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .toggle_i  (swap_now),
        .rd_idx_i  (idx_q),
        .rd_data_o (front_data)
    );

    // Trigger detection, swap decision (a commit on the trigger edge still
    // counts) and next values for the frame timer and pending-swap flag.
    always_comb begin
        timer_wrap  = (timer_q == TW'(FRAME_PERIOD - 1));
        trigger     = timer_wrap || kick_i;
        timer_d     = timer_wrap ? '0 : timer_q + 1'b1;
        swap_now    = (state_q == IDLE) && trigger && (swap_pend_q || commit_i);
        swap_pend_d = swap_now ? 1'b0 : (swap_pend_q || commit_i);
        at_last     = (idx_q == AW'(LED_COUNT - 1));
    end

    // Frame sequencing IDLE -> STREAM -> LATCH -> IDLE with registered
    // handshake, status and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            swap_pend_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            swap_pend_q   <= swap_pend_d;
            frame_start_q <= 1'b0;
            overrun_q     <= trigger && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q       <= STREAM;
                        idx_q         <= '0;
                        frame_start_q <= 1'b1;
                        pix_valid_q   <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pix_ready_i) begin
                        if (at_last) begin
                            state_q     <= LATCH;
                            cnt_q       <= '0;
                            pix_valid_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pix_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign frame_start_o = frame_start_q;
    assign pix_valid_o   = pix_valid_q;
    assign pix_data_o    = pix_valid_q ? front_data : '0;
    assign pix_last_o    = pix_valid_q && at_last;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;

endmodule
